// File: rtl/spi_req_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of spi_master.
// One spi_master transaction per grant, result routed back to the owner, watchdog abort.
module spi_req_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req0_valid,
  input  logic [1:0]  req0_mode,
  input  logic [15:0] req0_sdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic        req0_err,
  output logic [15:0] req0_rdata,
  input  logic        req1_valid,
  input  logic [1:0]  req1_mode,
  input  logic [15:0] req1_sdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req1_err,
  output logic [15:0] req1_rdata,
  output logic        m_spi_en,
  output logic [1:0]  m_spi_mode,
  output logic [15:0] m_spi_sdata,
  input  logic        m_spi_done,
  input  logic [15:0] m_spi_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nx;
  logic        owner, owner_nx;
  logic        rr, rr_nx;
  logic        err_int, err_nx;
  logic        grant;
  logic [15:0] cnt, cnt_nx;
  logic [15:0] word_nx;
  logic [1:0]  mode_nx;
  logic [15:0] sdata_nx;

  logic        en_nx, busy_nx;
  logic        ready0_nx, ready1_nx;
  logic        done0_nx, done1_nx;

  // State, datapath and output registers; outputs are loaded from next-state values
  // so that every output is a flop yet lines up with the state it belongs to.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      rr          <= 1'b0;
      cnt         <= '0;
      err_int     <= 1'b0;
      m_spi_en    <= 1'b0;
      m_spi_mode  <= '0;
      m_spi_sdata <= '0;
      busy        <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      req0_err    <= 1'b0;
      req1_err    <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      rr          <= rr_nx;
      cnt         <= cnt_nx;
      err_int     <= err_nx;
      m_spi_en    <= en_nx;
      m_spi_mode  <= mode_nx;
      m_spi_sdata <= sdata_nx;
      busy        <= busy_nx;
      req0_ready  <= ready0_nx;
      req1_ready  <= ready1_nx;
      req0_done   <= done0_nx;
      req1_done   <= done1_nx;
      req0_err    <= done0_nx & err_nx;
      req1_err    <= done1_nx & err_nx;
      if (done0_nx) req0_rdata <= word_nx;
      if (done1_nx) req1_rdata <= word_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_nx    = rr;
    cnt_nx   = cnt;
    err_nx   = err_int;
    word_nx  = '0;
    mode_nx  = m_spi_mode;
    sdata_nx = m_spi_sdata;
    grant    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant    = (req0_valid && req1_valid) ? rr : req1_valid;
          owner_nx = grant;
          mode_nx  = grant ? req1_mode  : req0_mode;
          sdata_nx = grant ? req1_sdata : req0_sdata;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        rr_nx    = ~owner;
        cnt_nx   = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        // done is tested before the limit, so a done on the last cycle is not an error
        if (m_spi_done) begin
          word_nx  = m_spi_rdata;
          err_nx   = 1'b0;
          state_nx = RESP;
        end else if (cnt == LIMIT) begin
          word_nx  = '0;
          err_nx   = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx   = cnt + 16'd1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    en_nx     = (state_nx == ISSUE);
    busy_nx   = (state_nx != IDLE);
    ready0_nx = en_nx && !owner_nx;
    ready1_nx = en_nx &&  owner_nx;
    done0_nx  = (state_nx == RESP) && !owner_nx;
    done1_nx  = (state_nx == RESP) &&  owner_nx;
  end

endmodule
